ycbcr_to_rgb565: RTL and testbench
==================================

Name: ycbcr_to_rgb565

Overview:
- Inverse of the camera-path RGB565→YCbCr converter: takes 8-bit Y/Cb/Cr pixels with video sync and produces RGB565 pixels plus delayed sync.
- Sits after the YCbCr-domain processing (skin mask, filtering) and feeds the LCD/SDRAM display path.
- Fixed 3-stage pipeline, BT.601 full-range, integer coefficients ×256, saturating output.
- Also provides a per-frame output-pixel counter for debug.

Parameters:
- CNT_W, 20, width of the per-frame pixel counter (fits 1024×768).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- pre_frame_vsync  in  1  input vsync
- pre_frame_hsync  in  1  input hsync
- pre_frame_de  in  1  input data enable
- img_y  in  8  luma
- img_cb  in  8  blue-difference chroma
- img_cr  in  8  red-difference chroma
- mode  in  4  operating mode; conversion updates only when mode ∈ {1,2,3,4,5}
- post_frame_vsync  out  1  vsync delayed 3 cycles
- post_frame_hsync  out  1  hsync delayed 3 cycles
- post_frame_de  out  1  de delayed 3 cycles
- img_red  out  5  R[7:3]
- img_green  out  6  G[7:2]
- img_blue  out  5  B[7:3]
- pixel_cnt  out  CNT_W  count of post_frame_de-high cycles in the current frame

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). All registers clear to 0 on reset. All outputs read 0 during and after reset until new data propagates.
- Stage 1 (registered) products:
  - y256 = Y·256
  - r_cr = 359·Cr
  - g_cb = 88·Cb
  - g_cr = 183·Cr
  - b_cb = 454·Cb
  - Each product is 17 bits unsigned.
- Stage 2 (registered) sums, 19-bit signed:
  - R0 = y256 + r_cr − 45952
  - G0 = y256 − g_cb − g_cr + 34688
  - B0 = y256 + b_cb − 58112
- Stage 3 (registered, only when mode ∈ {1..5}; otherwise holds its previous value):
  - Arithmetic shift >>8, then clamp: negative → 0, >255 → 255.
  - Store R8/G8/B8.
- Output:
  - {img_red, img_green, img_blue} = {R8[7:3], G8[7:2], B8[7:3]} when post_frame_de = 1, else all zero (combinational gate on the registered values).
- Latency: exactly 3 cycles from input pixel to output. Each sync signal passes through a 3-bit shift register so it stays aligned with the data. Sync delay is unaffected by mode.
- Throughput: 1 pixel per clock, no backpressure, no stalls.
- pixel_cnt:
  - Clears to 0 on the cycle after a post_frame_vsync rising edge.
  - Otherwise increments by 1 on each cycle with post_frame_de = 1.
  - Saturates at all-ones (no wrap).
  - If clear and de coincide, clear wins and that pixel is not counted.
- Mode change mid-line takes effect at the next stage-3 update; already-held values remain until then.
- Reset mid-frame: pipeline, sync delays and counter clear immediately. Outputs resume correct data 3 cycles after reset release.

Test Plan:
- Y=128, Cb=128, Cr=128, de=1, mode=1 → after 3 cycles RGB565 = 16'h8410 (R=16, G=32, B=16), post_frame_de=1.
- Y=255, Cb=128, Cr=255 → R clamps to 255, G=164, B=255 → 16'hFD3F. Checks upper saturation.
- Y=0, Cb=128, Cr=0 → R negative clamps to 0, G=91, B=0 → 16'h02C0. Checks lower saturation.
- Stream of 5 distinct pixels with vsync/hsync/de toggling → each output pixel and sync edge appears exactly 3 cycles after input; de=0 cycles give RGB=0.
- mode=0 after one pixel converted → RGB stays at last value while de=1 and the inputs change; mode=2 restores updating.
- Frame of 100 de cycles, vsync pulse, then 40 de cycles → pixel_cnt reaches 100, clears after the post_frame_vsync rising edge, then reaches 40. Assert rst_n mid-frame → all outputs 0 asynchronously.

Source files
------------

// File: rtl/ycbcr_to_rgb565.sv
// BT.601 full-range YCbCr to RGB565 converter: 3-stage pipeline with saturating output,
// sync signals delayed to stay aligned with the data, and a per-frame output pixel counter.
`timescale 1ns/1ps

module ycbcr_to_rgb565 #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_frame_vsync,
    input  logic             pre_frame_hsync,
    input  logic             pre_frame_de,
    input  logic [7:0]       img_y,
    input  logic [7:0]       img_cb,
    input  logic [7:0]       img_cr,
    input  logic [3:0]       mode,
    output logic             post_frame_vsync,
    output logic             post_frame_hsync,
    output logic             post_frame_de,
    output logic [4:0]       img_red,
    output logic [5:0]       img_green,
    output logic [4:0]       img_blue,
    output logic [CNT_W-1:0] pixel_cnt
);

    localparam int DATA_W = 8;
    localparam int PROD_W = 17;
    localparam int SUM_W  = 19;

    localparam logic [PROD_W-1:0] K_R_CR = 17'd359;
    localparam logic [PROD_W-1:0] K_G_CB = 17'd88;
    localparam logic [PROD_W-1:0] K_G_CR = 17'd183;
    localparam logic [PROD_W-1:0] K_B_CB = 17'd454;

    localparam logic signed [SUM_W-1:0] OFF_R = -19'sd45952;
    localparam logic signed [SUM_W-1:0] OFF_G =  19'sd34688;
    localparam logic signed [SUM_W-1:0] OFF_B = -19'sd58112;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Drop the x256 scale (arithmetic shift), then clamp into 0..255.
    function automatic logic [DATA_W-1:0] sat_u8(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] s;
        s = v >>> 8;
        if (s < 0)
            return '0;
        else if (s > 19'sd255)
            return 8'hFF;
        else
            return s[DATA_W-1:0];
    endfunction

    logic [PROD_W-1:0] w_cb_ext;
    logic [PROD_W-1:0] w_cr_ext;
    assign w_cb_ext = {9'd0, img_cb};
    assign w_cr_ext = {9'd0, img_cr};

    // Stage 1: unsigned products
    logic [PROD_W-1:0] r_y256_p0;
    logic [PROD_W-1:0] r_r_cr_p0;
    logic [PROD_W-1:0] r_g_cb_p0;
    logic [PROD_W-1:0] r_g_cr_p0;
    logic [PROD_W-1:0] r_b_cb_p0;
    logic [2:0]        r_sync_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y256_p0 <= '0;
            r_r_cr_p0 <= '0;
            r_g_cb_p0 <= '0;
            r_g_cr_p0 <= '0;
            r_b_cb_p0 <= '0;
            r_sync_p0 <= '0;
        end else begin
            r_y256_p0 <= {1'b0, img_y, 8'd0};
            r_r_cr_p0 <= w_cr_ext * K_R_CR;
            r_g_cb_p0 <= w_cb_ext * K_G_CB;
            r_g_cr_p0 <= w_cr_ext * K_G_CR;
            r_b_cb_p0 <= w_cb_ext * K_B_CB;
            r_sync_p0 <= {pre_frame_vsync, pre_frame_hsync, pre_frame_de};
        end
    end

    logic signed [SUM_W-1:0] w_y_s;
    logic signed [SUM_W-1:0] w_r_cr_s;
    logic signed [SUM_W-1:0] w_g_cb_s;
    logic signed [SUM_W-1:0] w_g_cr_s;
    logic signed [SUM_W-1:0] w_b_cb_s;
    assign w_y_s    = $signed({2'b00, r_y256_p0});
    assign w_r_cr_s = $signed({2'b00, r_r_cr_p0});
    assign w_g_cb_s = $signed({2'b00, r_g_cb_p0});
    assign w_g_cr_s = $signed({2'b00, r_g_cr_p0});
    assign w_b_cb_s = $signed({2'b00, r_b_cb_p0});

    // Stage 2: signed sums with the chroma offsets folded in
    logic signed [SUM_W-1:0] r_r0_p1;
    logic signed [SUM_W-1:0] r_g0_p1;
    logic signed [SUM_W-1:0] r_b0_p1;
    logic [2:0]              r_sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r0_p1   <= '0;
            r_g0_p1   <= '0;
            r_b0_p1   <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_r0_p1   <= w_y_s + w_r_cr_s + OFF_R;
            r_g0_p1   <= w_y_s - w_g_cb_s - w_g_cr_s + OFF_G;
            r_b0_p1   <= w_y_s + w_b_cb_s + OFF_B;
            r_sync_p1 <= r_sync_p0;
        end
    end

    logic w_mode_ok;
    assign w_mode_ok = (mode >= 4'd1) && (mode <= 4'd5);

    // Stage 3: saturate and hold when the mode disables conversion; sync is never held
    logic [DATA_W-1:0] r_r8_p2;
    logic [DATA_W-1:0] r_g8_p2;
    logic [DATA_W-1:0] r_b8_p2;
    logic [2:0]        r_sync_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r8_p2   <= '0;
            r_g8_p2   <= '0;
            r_b8_p2   <= '0;
            r_sync_p2 <= '0;
        end else begin
            if (w_mode_ok) begin
                r_r8_p2 <= sat_u8(r_r0_p1);
                r_g8_p2 <= sat_u8(r_g0_p1);
                r_b8_p2 <= sat_u8(r_b0_p1);
            end
            r_sync_p2 <= r_sync_p1;
        end
    end

    assign post_frame_vsync = r_sync_p2[2];
    assign post_frame_hsync = r_sync_p2[1];
    assign post_frame_de    = r_sync_p2[0];

    assign img_red   = post_frame_de ? r_r8_p2[7:3] : '0;
    assign img_green = post_frame_de ? r_g8_p2[7:2] : '0;
    assign img_blue  = post_frame_de ? r_b8_p2[7:3] : '0;

    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{r_r8_p2[2:0], r_g8_p2[1:0], r_b8_p2[2:0]};

    // Frame counter: a vsync rising edge at the output clears it, taking priority over de
    logic             r_vs_prev;
    logic [CNT_W-1:0] r_pixel_cnt;
    logic             w_vs_rise;
    logic             w_cnt_full;
    assign w_vs_rise  = post_frame_vsync & ~r_vs_prev;
    assign w_cnt_full = &r_pixel_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev   <= 1'b0;
            r_pixel_cnt <= '0;
        end else begin
            r_vs_prev <= post_frame_vsync;
            if (w_vs_rise)
                r_pixel_cnt <= '0;
            else if (post_frame_de && !w_cnt_full)
                r_pixel_cnt <= r_pixel_cnt + CNT_ONE;
        end
    end

    assign pixel_cnt = r_pixel_cnt;

endmodule

// File: tb/tb_ycbcr_to_rgb565.sv
// Scoreboard bench for ycbcr_to_rgb565: expected pixels are queued as stimulus is driven
// and popped three cycles later when the DUT presents them.
`timescale 1ns/1ps

module tb_ycbcr_to_rgb565;

    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pre_frame_vsync = 1'b0;
    logic             pre_frame_hsync = 1'b0;
    logic             pre_frame_de = 1'b0;
    logic [7:0]       img_y = '0;
    logic [7:0]       img_cb = '0;
    logic [7:0]       img_cr = '0;
    logic [3:0]       mode = 4'd1;
    logic             post_frame_vsync;
    logic             post_frame_hsync;
    logic             post_frame_de;
    logic [4:0]       img_red;
    logic [5:0]       img_green;
    logic [4:0]       img_blue;
    logic [CNT_W-1:0] pixel_cnt;

    ycbcr_to_rgb565 #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_hsync  (pre_frame_hsync),
        .pre_frame_de     (pre_frame_de),
        .img_y            (img_y),
        .img_cb           (img_cb),
        .img_cr           (img_cr),
        .mode             (mode),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_de    (post_frame_de),
        .img_red          (img_red),
        .img_green        (img_green),
        .img_blue         (img_blue),
        .pixel_cnt        (pixel_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vs;
        logic        hs;
        logic        de;
        logic [15:0] conv;
    } ent_t;

    ent_t             sb[$];
    int               n_chk = 0;
    int               n_fail = 0;
    logic [15:0]      m_held = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_prev_vs = 1'b0;

    function automatic logic [7:0] clamp255(int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [15:0] conv565(int y, int cb, int cr);
        logic [7:0] r8, g8, b8;
        r8 = clamp255((y * 256 + 359 * cr - 45952) >>> 8);
        g8 = clamp255((y * 256 - 88 * cb - 183 * cr + 34688) >>> 8);
        b8 = clamp255((y * 256 + 454 * cb - 58112) >>> 8);
        return {r8[7:3], g8[7:2], b8[7:3]};
    endfunction

    task automatic push_px(input logic vs, input logic hs, input logic de, input logic [7:0] y,
                           input logic [7:0] cb, input logic [7:0] cr, input logic [3:0] md,
                           input logic [15:0] conv);
        ent_t e;
        pre_frame_vsync = vs;
        pre_frame_hsync = hs;
        pre_frame_de    = de;
        img_y           = y;
        img_cb          = cb;
        img_cr          = cr;
        mode            = md;
        e.vs = vs; e.hs = hs; e.de = de; e.conv = conv;
        sb.push_back(e);
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input logic [7:0] y,
                         input logic [7:0] cb, input logic [7:0] cr, input logic [3:0] md);
        push_px(vs, hs, de, y, cb, cr, md, conv565(int'(y), int'(cb), int'(cr)));
    endtask

    // Stage 3 samples the mode pins at the edge just before this observation, so the
    // mode currently on the pins decides whether the held value takes the new pixel.
    task automatic model_pop(output logic [2:0] x_sync, output logic [15:0] x_rgb,
                             output logic [CNT_W-1:0] x_cnt);
        ent_t e;
        e = sb.pop_front();
        if (mode >= 4'd1 && mode <= 4'd5) m_held = e.conv;
        x_sync = {e.vs, e.hs, e.de};
        x_rgb  = e.de ? m_held : 16'h0000;
        x_cnt  = m_cnt;
        if (e.vs && !m_prev_vs) m_cnt = '0;
        else if (e.de && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        m_prev_vs = e.vs;
    endtask

    task automatic model_clear();
        sb.delete();
        m_held    = '0;
        m_cnt     = '0;
        m_prev_vs = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'd1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sync: got %b want 000", {post_frame_vsync, post_frame_hsync, post_frame_de});
        end
        n_chk++;
        if ({img_red, img_green, img_blue} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rgb: got %h want 0000", {img_red, img_green, img_blue});
        end
        n_chk++;
        if (pixel_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", pixel_cnt);
        end
        model_clear();
        release_reset();
    endtask

    task automatic test_saturation();
        logic [7:0]  ty [3] = '{8'd128, 8'd255, 8'd0};
        logic [7:0]  tc [3] = '{8'd128, 8'd255, 8'd0};
        logic [15:0] tx [3] = '{16'h8410, 16'hFD3F, 16'h02C0};
        logic [2:0]  xs;
        logic [15:0] xr;
        logic [CNT_W-1:0] xc;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                model_pop(xs, xr, xc);
                n_chk++;
                if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== xs ||
                    {img_red, img_green, img_blue} !== xr || pixel_cnt !== xc) begin
                    n_fail++;
                    $display("FAIL saturation[%0d]: got sync=%b rgb=%h cnt=%0d want sync=%b rgb=%h cnt=%0d",
                             i, {post_frame_vsync, post_frame_hsync, post_frame_de},
                             {img_red, img_green, img_blue}, pixel_cnt, xs, xr, xc);
                end
            end
            if (i < 3) push_px(1'b0, 1'b1, 1'b1, ty[i], 8'd128, tc[i], 4'd1, tx[i]);
            else       drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'd1);
        end
    endtask

    task automatic test_stream();
        logic [2:0] tsync [8] = '{3'b100, 3'b011, 3'b001, 3'b010, 3'b011, 3'b101, 3'b001, 3'b000};
        logic [7:0] ty [8] = '{8'd10, 8'd200, 8'd60, 8'd255, 8'd30, 8'd150, 8'd90, 8'd0};
        logic [7:0] tb [8] = '{8'd20, 8'd50, 8'd200, 8'd255, 8'd100, 8'd10, 8'd160, 8'd0};
        logic [7:0] tr [8] = '{8'd30, 8'd180, 8'd90, 8'd255, 8'd220, 8'd40, 8'd120, 8'd0};
        logic [2:0]  xs;
        logic [15:0] xr;
        logic [CNT_W-1:0] xc;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                model_pop(xs, xr, xc);
                n_chk++;
                if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== xs ||
                    {img_red, img_green, img_blue} !== xr || pixel_cnt !== xc) begin
                    n_fail++;
                    $display("FAIL stream[%0d]: got sync=%b rgb=%h cnt=%0d want sync=%b rgb=%h cnt=%0d",
                             i, {post_frame_vsync, post_frame_hsync, post_frame_de},
                             {img_red, img_green, img_blue}, pixel_cnt, xs, xr, xc);
                end
            end
            if (i < 8) drive(tsync[i][2], tsync[i][1], tsync[i][0], ty[i], tb[i], tr[i], 4'd1);
            else       drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'd1);
        end
    endtask

    task automatic test_mode_hold();
        logic [3:0]  md;
        logic [7:0]  y, cb, cr;
        logic [2:0]  xs;
        logic [15:0] xr;
        logic [CNT_W-1:0] xc;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                model_pop(xs, xr, xc);
                n_chk++;
                if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== xs ||
                    {img_red, img_green, img_blue} !== xr || pixel_cnt !== xc) begin
                    n_fail++;
                    $display("FAIL mode_hold[%0d]: got sync=%b rgb=%h cnt=%0d want sync=%b rgb=%h cnt=%0d",
                             i, {post_frame_vsync, post_frame_hsync, post_frame_de},
                             {img_red, img_green, img_blue}, pixel_cnt, xs, xr, xc);
                end
            end
            if (i < 3)       begin md = 4'd1; y = 8'd100; cb = 8'd90; cr = 8'd200; end
            else if (i < 8)  begin md = 4'd0; y = 8'(20 * i); cb = 8'(230 - 10 * i); cr = 8'(15 * i); end
            else if (i < 10) begin md = 4'd9; y = 8'd250; cb = 8'd10; cr = 8'd10; end
            else             begin md = 4'd2; y = 8'(40 + 13 * i); cb = 8'(7 * i); cr = 8'(200 - 9 * i); end
            drive(1'b0, 1'b1, 1'b1, y, cb, cr, md);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  xs;
        logic [15:0] xr;
        logic [CNT_W-1:0] xc;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                model_pop(xs, xr, xc);
                n_chk++;
                if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== xs ||
                    {img_red, img_green, img_blue} !== xr || pixel_cnt !== xc) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d]: got sync=%b rgb=%h cnt=%0d want sync=%b rgb=%h cnt=%0d",
                             i, {post_frame_vsync, post_frame_hsync, post_frame_de},
                             {img_red, img_green, img_blue}, pixel_cnt, xs, xr, xc);
                end
            end
            if (i < 60)
                drive(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      4'($urandom_range(0, 7)));
            else
                drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'd1);
        end
    endtask

    task automatic test_counter();
        logic [2:0]  xs;
        logic [15:0] xr;
        logic [CNT_W-1:0] xc;
        int          n_de [2] = '{100, 40};
        logic        vs, de;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < n_de[f] + 9; i++) begin
                @(negedge clk);
                if (sb.size() >= 3) begin
                    model_pop(xs, xr, xc);
                    n_chk++;
                    if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== xs ||
                        {img_red, img_green, img_blue} !== xr || pixel_cnt !== xc) begin
                        n_fail++;
                        $display("FAIL counter_f%0d[%0d]: got sync=%b rgb=%h cnt=%0d want sync=%b rgb=%h cnt=%0d",
                                 f, i, {post_frame_vsync, post_frame_hsync, post_frame_de},
                                 {img_red, img_green, img_blue}, pixel_cnt, xs, xr, xc);
                    end
                end
                vs = (i < 2);
                de = (i >= 4) && (i < n_de[f] + 4);
                drive(vs, de, de, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 4'd1);
            end
            n_chk++;
            if (pixel_cnt !== CNT_W'(n_de[f])) begin
                n_fail++;
                $display("FAIL frame_count_%0d: got %0d want %0d", f, pixel_cnt, n_de[f]);
            end
        end

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                model_pop(xs, xr, xc);
                n_chk++;
                if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== xs ||
                    {img_red, img_green, img_blue} !== xr || pixel_cnt !== xc) begin
                    n_fail++;
                    $display("FAIL pre_reset[%0d]: got sync=%b rgb=%h cnt=%0d want sync=%b rgb=%h cnt=%0d",
                             i, {post_frame_vsync, post_frame_hsync, post_frame_de},
                             {img_red, img_green, img_blue}, pixel_cnt, xs, xr, xc);
                end
            end
            drive(1'b0, 1'b1, 1'b1, 8'd255, 8'd60, 8'd200, 4'd1);
        end

        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset_sync: got %b want 000", {post_frame_vsync, post_frame_hsync, post_frame_de});
        end
        n_chk++;
        if ({img_red, img_green, img_blue} !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_rgb: got %h want 0000", {img_red, img_green, img_blue});
        end
        n_chk++;
        if (pixel_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset_cnt: got %0d want 0", pixel_cnt);
        end
        model_clear();
        pre_frame_vsync = 1'b0;
        pre_frame_hsync = 1'b0;
        pre_frame_de    = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sb.size() >= 3) begin
                model_pop(xs, xr, xc);
                n_chk++;
                if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== xs ||
                    {img_red, img_green, img_blue} !== xr || pixel_cnt !== xc) begin
                    n_fail++;
                    $display("FAIL post_reset[%0d]: got sync=%b rgb=%h cnt=%0d want sync=%b rgb=%h cnt=%0d",
                             i, {post_frame_vsync, post_frame_hsync, post_frame_de},
                             {img_red, img_green, img_blue}, pixel_cnt, xs, xr, xc);
                end
            end
            if (i < 8) drive(1'b0, 1'b1, 1'b1, 8'(30 * i), 8'(255 - 20 * i), 8'(17 * i), 4'd3);
            else       drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'd3);
        end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_stream();
        test_mode_hold();
        test_back_to_back();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
